// File: rtl/ps2_scan_receiver_if.sv
// rtl/ps2_scan_receiver_if.sv - PS/2 line inputs and received scan-code outputs
interface ps2_scan_receiver_if;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] scanCode;
  logic       scanCodeReady;
  logic       parityError;
  logic       frameError;

  modport master (
    output ps2Clk,
    output ps2Data,
    input  scanCode,
    input  scanCodeReady,
    input  parityError,
    input  frameError
  );

  modport slave (
    input  ps2Clk,
    input  ps2Data,
    output scanCode,
    output scanCodeReady,
    output parityError,
    output frameError
  );
endinterface

// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 keyboard frame receiver with parity, stop and timeout checks
// Optional PS2_GLITCH_FILTER_EN: 4-sample ps2Clk glitch filter before edge detection.
module ps2_scan_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic clk,
  input logic rst,
  ps2_scan_receiver_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [1:0]    clkSync;
  logic [1:0]    dataSync;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          parityOk;
  logic [CW-1:0] toCnt;
  logic          fall;
  logic          dIn;

  assign dIn = dataSync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
    end else begin
      clkSync  <= {clkSync[0], bus.ps2Clk};
      dataSync <= {dataSync[0], bus.ps2Data};
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  logic [2:0] clkHist;
  logic       clkFilt;

  // Edge is flagged in the cycle the filter commits to low, so the FSM acts with it.
  assign fall = clkFilt && ({clkHist, clkSync[1]} == 4'b0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkHist <= 3'b111;
      clkFilt <= 1'b1;
    end else begin
      clkHist <= {clkHist[1:0], clkSync[1]};
      if ({clkHist, clkSync[1]} == 4'b0000) begin
        clkFilt <= 1'b0;
      end else if ({clkHist, clkSync[1]} == 4'b1111) begin
        clkFilt <= 1'b1;
      end
    end
  end
`else
  logic clkPrev;

  assign fall = clkPrev && !clkSync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkPrev <= 1'b1;
    end else begin
      clkPrev <= clkSync[1];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      bitCnt            <= 3'd0;
      shiftReg          <= 8'h00;
      parityOk          <= 1'b0;
      toCnt             <= '0;
      bus.scanCode      <= 8'h00;
      bus.scanCodeReady <= 1'b0;
      bus.parityError   <= 1'b0;
      bus.frameError    <= 1'b0;
    end else begin
      bus.scanCodeReady <= 1'b0;
      bus.parityError   <= 1'b0;
      bus.frameError    <= 1'b0;

      if (state == IDLE || fall) begin
        toCnt <= '0;
      end else if (toCnt != TIMEOUT_MAX) begin
        toCnt <= toCnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (fall && !dIn) begin
            state    <= DATA;
            bitCnt   <= 3'd0;
            shiftReg <= 8'h00;
          end
        end
        DATA: begin
          if (fall) begin
            shiftReg <= {dIn, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            parityOk <= (dIn == ~^shiftReg);
            state    <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            // Bad parity wins over a bad stop bit.
            if (!parityOk) begin
              bus.parityError <= 1'b1;
            end else if (!dIn) begin
              bus.frameError <= 1'b1;
            end else begin
              bus.scanCode      <= shiftReg;
              bus.scanCodeReady <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE && !fall && toCnt == TIMEOUT_MAX) begin
        state          <= IDLE;
        bitCnt         <= 3'd0;
        shiftReg       <= 8'h00;
        toCnt          <= '0;
        bus.frameError <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb/tb_ps2_scan_receiver.sv - randomized self-checking bench for ps2_scan_receiver
module tb_ps2_scan_receiver;
  localparam int TO = 1000;
`ifdef PS2_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_scan_receiver_if bus ();

  ps2_scan_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int cmpCnt = 0;
  int errCnt = 0;
  int cyc = 0;
  int readyCnt = 0, parCnt = 0, frmCnt = 0, overlapCnt = 0;
  int readyCyc = 0, lastFallCyc = 0, stopCyc = 0;
  logic [7:0] expCode = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.scanCodeReady === 1'b1) begin
      readyCnt++;
      readyCyc = cyc;
    end
    if (bus.parityError === 1'b1) parCnt++;
    if (bus.frameError === 1'b1) frmCnt++;
    if (int'(bus.scanCodeReady) + int'(bus.parityError) + int'(bus.frameError) > 1) overlapCnt++;
  end

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic oddPar(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic b, input int highCyc, input bit glitch);
    bus.ps2Data = b;
    if (glitch) begin
      waitCycles(highCyc / 2);
      bus.ps2Clk = 1'b0;
      waitCycles(1);
      bus.ps2Clk = 1'b1;
      waitCycles(highCyc - highCyc / 2 - 1);
    end else begin
      waitCycles(highCyc);
    end
    bus.ps2Clk = 1'b0;
    lastFallCyc = cyc;
    waitCycles(40);
    bus.ps2Clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s,
                           input int firstHigh, input bit glitch);
    sendBit(1'b0, firstHigh, glitch);
    for (int i = 0; i < 8; i++) sendBit(d[i], 40, glitch);
    sendBit(p, 40, glitch);
    sendBit(s, 40, glitch);
    stopCyc = lastFallCyc;
    bus.ps2Data = 1'b1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmpCnt++;
      if ({bus.scanCode, bus.scanCodeReady, bus.parityError, bus.frameError} !== 11'd0) begin
        errCnt++;
        $display("FAIL reset_outputs cycle %0d: got %h, want 0", i,
                 {bus.scanCode, bus.scanCodeReady, bus.parityError, bus.frameError});
      end
    end
    rst = 1'b1;
    waitCycles(10);
    cmpCnt++;
    if (readyCnt + parCnt + frmCnt !== 0) begin
      errCnt++;
      $display("FAIL reset_release_pulses: got %0d, want 0", readyCnt + parCnt + frmCnt);
    end
  endtask

  task automatic test_single;
    int r0 = readyCnt, p0 = parCnt, f0 = frmCnt;
    sendFrame(8'h1C, oddPar(8'h1C), 1'b1, 40, 1'b0);
    expCode = 8'h1C;
    waitCycles(5);
    cmpCnt++;
    if (readyCnt - r0 !== 1) begin
      errCnt++;
      $display("FAIL single_ready_count: got %0d, want 1", readyCnt - r0);
    end
    cmpCnt++;
    if (bus.scanCode !== expCode) begin
      errCnt++;
      $display("FAIL single_code: got %h, want %h", bus.scanCode, expCode);
    end
    cmpCnt++;
    if (readyCyc - stopCyc !== LAT) begin
      errCnt++;
      $display("FAIL single_latency: got %0d, want %0d", readyCyc - stopCyc, LAT);
    end
    cmpCnt++;
    if ((parCnt - p0) + (frmCnt - f0) !== 0) begin
      errCnt++;
      $display("FAIL single_errors: got %0d, want 0", (parCnt - p0) + (frmCnt - f0));
    end
  endtask

  task automatic test_back_to_back;
    int r0 = readyCnt;
    sendFrame(8'hF0, oddPar(8'hF0), 1'b1, 40, 1'b0);
    cmpCnt++;
    if (bus.scanCode !== 8'hF0) begin
      errCnt++;
      $display("FAIL b2b_first_code: got %h, want f0", bus.scanCode);
    end
    sendFrame(8'h1C, oddPar(8'h1C), 1'b1, 8, 1'b0);
    expCode = 8'h1C;
    waitCycles(5);
    cmpCnt++;
    if (readyCnt - r0 !== 2) begin
      errCnt++;
      $display("FAIL b2b_ready_count: got %0d, want 2", readyCnt - r0);
    end
    cmpCnt++;
    if (bus.scanCode !== expCode) begin
      errCnt++;
      $display("FAIL b2b_second_code: got %h, want %h", bus.scanCode, expCode);
    end
  endtask

  task automatic test_errors;
    int r0 = readyCnt, p0 = parCnt, f0 = frmCnt;
    sendFrame(8'h1C, ~oddPar(8'h1C), 1'b1, 40, 1'b0);
    waitCycles(5);
    cmpCnt++;
    if ({readyCnt - r0, parCnt - p0, frmCnt - f0} !== {32'd0, 32'd1, 32'd0}) begin
      errCnt++;
      $display("FAIL parity_pulses: got r%0d p%0d f%0d, want r0 p1 f0",
               readyCnt - r0, parCnt - p0, frmCnt - f0);
    end
    cmpCnt++;
    if (bus.scanCode !== expCode) begin
      errCnt++;
      $display("FAIL parity_code_hold: got %h, want %h", bus.scanCode, expCode);
    end
    r0 = readyCnt; p0 = parCnt; f0 = frmCnt;
    sendFrame(8'h12, oddPar(8'h12), 1'b0, 40, 1'b0);
    waitCycles(5);
    cmpCnt++;
    if ({readyCnt - r0, parCnt - p0, frmCnt - f0} !== {32'd0, 32'd0, 32'd1}) begin
      errCnt++;
      $display("FAIL stop_pulses: got r%0d p%0d f%0d, want r0 p0 f1",
               readyCnt - r0, parCnt - p0, frmCnt - f0);
    end
    cmpCnt++;
    if (bus.scanCode !== expCode) begin
      errCnt++;
      $display("FAIL stop_code_hold: got %h, want %h", bus.scanCode, expCode);
    end
  endtask

  task automatic test_idle_noise;
    int tot0 = readyCnt + parCnt + frmCnt;
    for (int i = 0; i < 3; i++) sendBit(1'b1, 40, 1'b0);
    waitCycles(40);
    cmpCnt++;
    if (readyCnt + parCnt + frmCnt - tot0 !== 0) begin
      errCnt++;
      $display("FAIL idle_noise_pulses: got %0d, want 0", readyCnt + parCnt + frmCnt - tot0);
    end
    sendFrame(8'h5A, oddPar(8'h5A), 1'b1, 40, 1'b0);
    expCode = 8'h5A;
    waitCycles(5);
    cmpCnt++;
    if (bus.scanCode !== expCode) begin
      errCnt++;
      $display("FAIL idle_noise_code: got %h, want %h", bus.scanCode, expCode);
    end
  endtask

  task automatic test_timeout;
    int r0 = readyCnt, p0 = parCnt, f0 = frmCnt;
    logic [7:0] d = 8'h1C;
    sendBit(1'b0, 40, 1'b0);
    for (int i = 0; i < 4; i++) sendBit(d[i], 40, 1'b0);
    bus.ps2Data = 1'b1;
    waitCycles(TO + 10);
    cmpCnt++;
    if ({readyCnt - r0, parCnt - p0, frmCnt - f0} !== {32'd0, 32'd0, 32'd1}) begin
      errCnt++;
      $display("FAIL timeout_pulses: got r%0d p%0d f%0d, want r0 p0 f1",
               readyCnt - r0, parCnt - p0, frmCnt - f0);
    end
    sendFrame(8'h12, oddPar(8'h12), 1'b1, 40, 1'b0);
    expCode = 8'h12;
    waitCycles(5);
    cmpCnt++;
    if (bus.scanCode !== expCode || readyCnt - r0 !== 1 || frmCnt - f0 !== 1) begin
      errCnt++;
      $display("FAIL timeout_recover: got code %h r%0d f%0d, want %h r1 f1",
               bus.scanCode, readyCnt - r0, frmCnt - f0, expCode);
    end
  endtask

  task automatic test_reset_midframe;
    int tot0 = readyCnt + parCnt + frmCnt;
    int r0;
    logic [7:0] d = 8'h1C;
    sendBit(1'b0, 40, 1'b0);
    for (int i = 0; i < 3; i++) sendBit(d[i], 40, 1'b0);
    waitCycles(5);
    rst = 1'b0;
    expCode = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmpCnt++;
      if ({bus.scanCode, bus.scanCodeReady, bus.parityError, bus.frameError} !== 11'd0) begin
        errCnt++;
        $display("FAIL midreset_outputs cycle %0d: got %h, want 0", i,
                 {bus.scanCode, bus.scanCodeReady, bus.parityError, bus.frameError});
      end
    end
    rst = 1'b1;
    bus.ps2Data = 1'b1;
    waitCycles(TO + 20);
    cmpCnt++;
    if (readyCnt + parCnt + frmCnt - tot0 !== 0) begin
      errCnt++;
      $display("FAIL midreset_pulses: got %0d, want 0", readyCnt + parCnt + frmCnt - tot0);
    end
    r0 = readyCnt;
    sendFrame(8'h12, oddPar(8'h12), 1'b1, 40, 1'b0);
    expCode = 8'h12;
    waitCycles(5);
    cmpCnt++;
    if (bus.scanCode !== expCode || readyCnt - r0 !== 1) begin
      errCnt++;
      $display("FAIL midreset_recover: got code %h r%0d, want %h r1",
               bus.scanCode, readyCnt - r0, expCode);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d = 8'($urandom);
      int kind = $urandom_range(0, 9);
      logic p = oddPar(d);
      logic s = 1'b1;
      int r0 = readyCnt, p0 = parCnt, f0 = frmCnt;
      int wr = 0, wp = 0, wf = 0;
      if (kind <= 1 || kind == 3) p = ~p;
      if (kind == 2 || kind == 3) s = 1'b0;
      if (p != oddPar(d)) wp = 1;
      else if (s == 1'b0) wf = 1;
      else begin
        wr = 1;
        expCode = d;
      end
      sendFrame(d, p, s, $urandom_range(8, 40), 1'b0);
      waitCycles(5);
      cmpCnt++;
      if (readyCnt - r0 !== wr || parCnt - p0 !== wp || frmCnt - f0 !== wf ||
          bus.scanCode !== expCode) begin
        errCnt++;
        $display("FAIL random_frame %0d data %h: got r%0d p%0d f%0d code %h, want r%0d p%0d f%0d code %h",
                 n, d, readyCnt - r0, parCnt - p0, frmCnt - f0, bus.scanCode, wr, wp, wf, expCode);
      end
      if (wr == 1) begin
        cmpCnt++;
        if (readyCyc - stopCyc !== LAT) begin
          errCnt++;
          $display("FAIL random_latency %0d: got %0d, want %0d", n, readyCyc - stopCyc, LAT);
        end
      end
    end
  endtask

`ifdef PS2_GLITCH_FILTER_EN
  task automatic test_glitch;
    int r0 = readyCnt, p0 = parCnt, f0 = frmCnt;
    sendFrame(8'h1C, oddPar(8'h1C), 1'b1, 40, 1'b1);
    expCode = 8'h1C;
    waitCycles(5);
    cmpCnt++;
    if (bus.scanCode !== expCode || readyCnt - r0 !== 1 || parCnt - p0 !== 0 || frmCnt - f0 !== 0) begin
      errCnt++;
      $display("FAIL glitch_frame: got code %h r%0d p%0d f%0d, want 1c r1 p0 f0",
               bus.scanCode, readyCnt - r0, parCnt - p0, frmCnt - f0);
    end
  endtask
`endif

  task automatic test_exclusive;
    cmpCnt++;
    if (overlapCnt !== 0) begin
      errCnt++;
      $display("FAIL exclusive_pulses: got %0d overlapping cycles, want 0", overlapCnt);
    end
  endtask

  initial begin
    bus.ps2Clk  = 1'b1;
    bus.ps2Data = 1'b1;
    #2 rst = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_idle_noise();
    test_timeout();
    test_reset_midframe();
    test_random();
`ifdef PS2_GLITCH_FILTER_EN
    test_glitch();
`endif
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end
endmodule

// File: doc/ps2_scan_receiver.md
PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, clk cycles without a PS/2 clock falling edge before an in-progress frame is abandoned.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 ps2Clk  input  1  raw PS/2 clock from keyboard, asynchronous to clk.
REQ-005 ps2Data  input  1  raw PS/2 data from keyboard, asynchronous to clk.
REQ-006 scanCode  output  8  last correctly received byte; feeds keyboard memory scanCode.
REQ-007 scanCodeReady  output  1  one-cycle pulse when scanCode is updated; feeds keyboard memory scanCodeReady.
REQ-008 parityError  output  1  one-cycle pulse on a frame dropped for bad parity.
REQ-009 frameError  output  1  one-cycle pulse on a frame dropped for stop bit = 0 or timeout.

Function
REQ-010 ps2Clk and ps2Data SHALL each pass a 2-flop synchronizer before use.
REQ-011 A bit SHALL be sampled from synchronized ps2Data in the cycle a falling edge of the synchronized (or filtered) ps2Clk is detected.
REQ-012 Frame SHALL be 11 bits: start 0, data D0..D7 LSB first, odd parity, stop 1.
REQ-013 FSM states IDLE, DATA, PARITY, STOP; reset state IDLE.
REQ-014 IDLE: edge with data 0 -> DATA, bit count 0; edge with data 1 -> stay IDLE, no output.
REQ-015 DATA: each edge shifts one bit in; after 8th bit -> PARITY.
REQ-016 PARITY: edge samples parity bit, compares to XOR of 8 data bits inverted; -> STOP.
REQ-017 STOP: edge with data 1 and parity good -> load scanCode, pulse scanCodeReady, -> IDLE.
REQ-018 STOP: parity bad -> pulse parityError only (precedence over stop check), scanCode unchanged, -> IDLE.
REQ-019 STOP: parity good, stop bit 0 -> pulse frameError, scanCode unchanged, -> IDLE.
REQ-020 Latency: scanCodeReady high exactly 3 clk cycles after the raw stop-bit ps2Clk falling edge (without filter).
REQ-021 scanCode SHALL hold its value between pulses; scanCodeReady, parityError, frameError never high simultaneously.
REQ-022 Timeout counter SHALL clear on every detected edge and count while state != IDLE; on reaching TIMEOUT_CYCLES -> pulse frameError, -> IDLE, partial byte discarded.
REQ-023 Timeout counter SHALL not count in IDLE and SHALL saturate, never wrap.
REQ-024 Back-to-back frames (next start edge in the first cycle after REQ-017 completes) SHALL be accepted without loss.

Reset
REQ-025 rst low SHALL immediately force: state IDLE, bit count 0, shift register 0x00, timeout counter 0, scanCode 0x00, scanCodeReady 0, parityError 0, frameError 0, synchronizer and filter flops 1 (PS/2 idle level).
REQ-026 Reset mid-frame SHALL discard the partial frame; no pulse on any output during or after release.
REQ-027 After rst release, the first falling edge SHALL be treated per IDLE rules.

Configuration
REQ-028 Macro PS2_GLITCH_FILTER_EN defined: synchronized ps2Clk SHALL pass a filter that changes state only after 4 consecutive equal samples; edge detection uses filtered clock; REQ-020 latency becomes 6 cycles.
REQ-029 Macro undefined: no filter; edge detection on synchronized ps2Clk directly; pulses shorter than 2 clk cycles may register as edges.

Verification
Bench: clk period 10, PS/2 half-bit period 40 clk cycles, rst low 2 cycles at start.
REQ-030 Frame 0x1C, parity 0, stop 1 -> one scanCodeReady pulse, scanCode = 0x1C, 3 cycles after stop edge (6 with filter).
REQ-031 Frames 0xF0 (parity 1) then 0x1C (parity 0) back-to-back -> two scanCodeReady pulses, scanCode 0xF0 then 0x1C; drive into keyboard memory, key value for ascii a reads 0.
REQ-032 Frame 0x1C with parity 1 -> parityError pulse, no scanCodeReady, scanCode keeps prior 0x1C/0x00; frame 0x12 stop 0 -> frameError pulse only.
REQ-033 Stop ps2Clk after 5 bits, wait TIMEOUT_CYCLES+10 -> one frameError pulse, state IDLE; following frame 0x12 (parity 1) -> scanCode = 0x12.
REQ-034 rst low after 4 bits of 0x1C, release, send 0x12 -> no pulses during reset, then scanCode = 0x12, all outputs 0 in reset.
REQ-035 With PS2_GLITCH_FILTER_EN: 1-cycle low glitch on ps2Clk inside each bit of frame 0x1C -> scanCode = 0x1C, no error pulses.
